// File: rtl/lightbike_pkg.sv
// Shared definitions for the lightbike round sequencer: state encoding, frame defaults, helpers.
package lightbike_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COUNTDOWN  = 3'd1,
    PLAYING    = 3'd2,
    ROUND_OVER = 3'd3,
    MATCH_OVER = 3'd4
  } state_t;

  localparam logic [2:0] WINNER_NONE = 3'd0;

  localparam int DEF_COUNTDOWN_FRAMES  = 180;
  localparam int DEF_ROUND_OVER_FRAMES = 120;
  localparam int DEF_WIN_SCORE         = 3;
  localparam int DEF_SCORE_W           = 4;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/lightbike_round_controller_frame_down_counter.sv
// Frame down-counter: done fires on the tick that consumes the last loaded frame.
module frame_down_counter (
  input  logic       clock,
  input  logic       resetn,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       tick,
  output logic       done
);

  // count holds frames remaining minus one, so done is simply count==0 on a tick
  logic [7:0] count;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_value - 8'd1;
    end else if (tick && count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign done = tick && (count == 8'd0);

endmodule

// File: rtl/lightbike_round_controller.sv
// Match/round sequencer for the lightbike arena: countdown, play, round result, match result.
module lightbike_round_controller
  import lightbike_pkg::*;
#(
  parameter int COUNTDOWN_FRAMES  = DEF_COUNTDOWN_FRAMES,
  parameter int ROUND_OVER_FRAMES = DEF_ROUND_OVER_FRAMES,
  parameter int WIN_SCORE         = DEF_WIN_SCORE,
  parameter int SCORE_W           = DEF_SCORE_W
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 four_player_mode,
  input  logic                 frame_tick,
  input  logic [3:0]           crash,
  output logic [2:0]           state,
  output logic                 bikes_enable,
  output logic                 arena_clear,
  output logic [3:0]           alive,
  output logic [2:0]           winner,
  output logic                 round_over,
  output logic                 match_over,
  output logic [4*SCORE_W-1:0] scores
);

  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

  state_t                   st;
  logic                     mode;
  logic [3:0][SCORE_W-1:0]  score_q;
  logic [3:0]               mask, next_alive;
  logic [2:0]               pc, next_winner;
  logic                     round_end, any_win, start_match;
  logic                     cnt_load, cnt_tick, cnt_done;
  logic [7:0]               cnt_value;

  assign state  = st;
  assign scores = score_q;

  always_comb begin
    mask        = mode ? 4'b1111 : 4'b0011;
    next_alive  = alive & ~(crash & mask);
    pc          = popcount4(next_alive);
    round_end   = (st == PLAYING) && (mode ? (pc <= 3'd1) : (pc < 3'd2));
    start_match = start && (st == IDLE || st == MATCH_OVER);
    next_winner = WINNER_NONE;
    any_win     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (pc == 3'd1 && next_alive[i]) next_winner = 3'(i + 1);
      if (score_q[i] >= WIN_S) any_win = 1'b1;
    end
    // load has priority inside the counter, so a coincident tick is dropped
    cnt_tick  = frame_tick && (st == COUNTDOWN || st == ROUND_OVER);
    cnt_load  = start_match || (st == ROUND_OVER && cnt_done && !any_win);
    cnt_value = 8'(COUNTDOWN_FRAMES);
    if (round_end) begin
      cnt_load  = 1'b1;
      cnt_value = 8'(ROUND_OVER_FRAMES);
    end
  end

  frame_down_counter u_counter (
    .clock      (clock),
    .resetn     (resetn),
    .load       (cnt_load),
    .load_value (cnt_value),
    .tick       (cnt_tick),
    .done       (cnt_done)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      st           <= IDLE;
      mode         <= 1'b0;
      alive        <= 4'b0000;
      winner       <= WINNER_NONE;
      score_q      <= '0;
      bikes_enable <= 1'b0;
      arena_clear  <= 1'b0;
      round_over   <= 1'b0;
      match_over   <= 1'b0;
    end else begin
      arena_clear <= 1'b0;
      round_over  <= 1'b0;
      case (st)
        IDLE, MATCH_OVER: begin
          if (start) begin
            st          <= COUNTDOWN;
            mode        <= four_player_mode;
            alive       <= four_player_mode ? 4'b1111 : 4'b0011;
            winner      <= WINNER_NONE;
            score_q     <= '0;
            arena_clear <= 1'b1;
            match_over  <= 1'b0;
          end
        end
        COUNTDOWN: begin
          if (cnt_done) begin
            st           <= PLAYING;
            bikes_enable <= 1'b1;
          end
        end
        PLAYING: begin
          alive <= next_alive;
          if (round_end) begin
            st           <= ROUND_OVER;
            bikes_enable <= 1'b0;
            round_over   <= 1'b1;
            winner       <= next_winner;
            for (int i = 0; i < 4; i++) begin
              if (next_winner == 3'(i + 1) && score_q[i] != '1)
                score_q[i] <= score_q[i] + 1'b1;
            end
          end
        end
        ROUND_OVER: begin
          if (cnt_done) begin
            if (any_win) begin
              st         <= MATCH_OVER;
              match_over <= 1'b1;
            end else begin
              st          <= COUNTDOWN;
              alive       <= mask;
              arena_clear <= 1'b1;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lightbike_round_controller.sv
// Directed bench: 2P and 4P rounds, draws, ignored inputs, tick/round-end overlap, match end, reset mid-round.
module tb_lightbike_round_controller;

  localparam int SW = 4;

  logic          clock = 1'b0;
  logic          resetn, start, four_player_mode, frame_tick;
  logic [3:0]    crash;
  logic [2:0]    state;
  logic          bikes_enable, arena_clear, round_over, match_over;
  logic [3:0]    alive;
  logic [2:0]    winner;
  logic [4*SW-1:0] scores;

  int n_cmp = 0;
  int n_err = 0;

  lightbike_round_controller #(
    .COUNTDOWN_FRAMES (2),
    .ROUND_OVER_FRAMES(3),
    .WIN_SCORE        (2),
    .SCORE_W          (SW)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .start           (start),
    .four_player_mode(four_player_mode),
    .frame_tick      (frame_tick),
    .crash           (crash),
    .state           (state),
    .bikes_enable    (bikes_enable),
    .arena_clear     (arena_clear),
    .alive           (alive),
    .winner          (winner),
    .round_over      (round_over),
    .match_over      (match_over),
    .scores          (scores)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; four_player_mode = 1'b0; frame_tick = 1'b0; crash = 4'b0;
    step(); step();
    chk("rst_state", 32'(state), 0);
    chk("rst_alive", 32'(alive), 0);
    chk("rst_scores", 32'(scores), 0);
    chk("rst_winner", 32'(winner), 0);
    chk("rst_enable", 32'(bikes_enable), 0);
    resetn = 1'b1;
    step();
    chk("idle_hold", 32'(state), 0);

    // 2P round 1
    start = 1'b1; step(); start = 1'b0;
    chk("r1_cd_state", 32'(state), 1);
    chk("r1_clear", 32'(arena_clear), 1);
    chk("r1_alive", 32'(alive), 4'b0011);
    crash = 4'b0001; step(); crash = 4'b0;
    chk("cd_crash_ign", 32'(alive), 4'b0011);
    chk("clear_1cyc", 32'(arena_clear), 0);
    ticks(1);
    chk("cd_after1", 32'(state), 1);
    ticks(1);
    chk("r1_play", 32'(state), 2);
    chk("r1_enable", 32'(bikes_enable), 1);
    start = 1'b1; step(); start = 1'b0;
    chk("start_ign_play", 32'(state), 2);
    crash = 4'b1100; step(); crash = 4'b0;
    chk("unused_crash_st", 32'(state), 2);
    chk("unused_crash_al", 32'(alive), 4'b0011);
    crash = 4'b0010; step(); crash = 4'b0;
    chk("r1_ro_state", 32'(state), 3);
    chk("r1_winner", 32'(winner), 1);
    chk("r1_scores", 32'(scores), 16'h0001);
    chk("r1_ro_pulse", 32'(round_over), 1);
    chk("r1_ro_enable", 32'(bikes_enable), 0);
    crash = 4'b0001; step(); crash = 4'b0;
    chk("ro_pulse_once", 32'(round_over), 0);
    chk("ro_crash_ign", 32'(alive), 4'b0001);
    ticks(2);
    chk("ro_after2", 32'(state), 3);
    ticks(1);
    chk("r2_cd", 32'(state), 1);
    chk("r2_clear", 32'(arena_clear), 1);
    chk("r2_alive", 32'(alive), 4'b0011);
    chk("winner_kept", 32'(winner), 1);

    // 2P round 2: draw
    ticks(2);
    chk("r2_play", 32'(state), 2);
    crash = 4'b0011; step(); crash = 4'b0;
    chk("r2_ro", 32'(state), 3);
    chk("r2_draw", 32'(winner), 0);
    chk("r2_scores", 32'(scores), 16'h0001);
    ticks(3);
    chk("r3_cd", 32'(state), 1);

    // 2P round 3: end of round with coincident tick, then match over
    ticks(2);
    chk("r3_play", 32'(state), 2);
    crash = 4'b0010; frame_tick = 1'b1; step(); crash = 4'b0; frame_tick = 1'b0;
    chk("r3_ro", 32'(state), 3);
    chk("r3_scores", 32'(scores), 16'h0002);
    ticks(2);
    chk("tick_not_carried", 32'(state), 3);
    ticks(1);
    chk("mo_state", 32'(state), 4);
    chk("mo_level", 32'(match_over), 1);
    step();
    chk("mo_hold_st", 32'(state), 4);
    chk("mo_hold_sc", 32'(scores), 16'h0002);
    chk("mo_hold_win", 32'(winner), 1);

    // restart in 4P mode
    start = 1'b1; four_player_mode = 1'b1; step(); start = 1'b0; four_player_mode = 1'b0;
    chk("m2_cd", 32'(state), 1);
    chk("m2_scores", 32'(scores), 0);
    chk("m2_clear", 32'(arena_clear), 1);
    chk("m2_alive", 32'(alive), 4'b1111);
    chk("m2_mo_low", 32'(match_over), 0);
    ticks(2);
    crash = 4'b0001; step();
    chk("4p_c1_st", 32'(state), 2);
    chk("4p_c1_al", 32'(alive), 4'b1110);
    crash = 4'b0100; step();
    chk("4p_c2_st", 32'(state), 2);
    crash = 4'b1000; step(); crash = 4'b0;
    chk("4p_c3_st", 32'(state), 3);
    chk("4p_winner", 32'(winner), 2);
    chk("4p_scores", 32'(scores), 16'h0010);
    chk("4p_alive", 32'(alive), 4'b0010);

    // 4P draw on final double crash
    ticks(3);
    chk("4p_r2_cd", 32'(state), 1);
    chk("4p_r2_alive", 32'(alive), 4'b1111);
    ticks(2);
    crash = 4'b1001; step();
    chk("4p_two_left", 32'(state), 2);
    crash = 4'b0110; step(); crash = 4'b0;
    chk("4p_draw_st", 32'(state), 3);
    chk("4p_draw_win", 32'(winner), 0);
    chk("4p_draw_sc", 32'(scores), 16'h0010);

    // reset mid-play with a crash in the same cycle
    ticks(3);
    ticks(2);
    chk("pre_rst_play", 32'(state), 2);
    resetn = 1'b0; crash = 4'b0001; step(); crash = 4'b0;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_scores", 32'(scores), 0);
    chk("mid_rst_alive", 32'(alive), 0);
    chk("mid_rst_winner", 32'(winner), 0);
    chk("mid_rst_enable", 32'(bikes_enable), 0);
    resetn = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lightbike_round_controller.md
Name: lightbike_round_controller

Overview:
Game-level sequencer for the lightbike arena. It runs a match as a series of rounds: idle, countdown, play, round-over display, and finally match-over. During play it tracks crash flags to decide when a round ends (2- or 4-player rules) and who won. It keeps per-player scores and drives the move-enable and arena-clear strobes consumed by the bike movement and VGA blocks.

Parameters:
COUNTDOWN_FRAMES, 180, frame_tick pulses spent in COUNTDOWN before play (3 s at 60 Hz)
ROUND_OVER_FRAMES, 120, frame_tick pulses spent showing the round result
WIN_SCORE, 3, round wins needed to take the match (1..15)
SCORE_W, 4, width of each player score counter

Ports:
clock  in  1  system clock
resetn  in  1  synchronous reset, active-low (sampled on rising clock edge)
start  in  1  level; begins a match from IDLE or MATCH_OVER
four_player_mode  in  1  1 = four bikes, 0 = bikes 1-2 only; sampled only on the IDLE/MATCH_OVER->COUNTDOWN transition
frame_tick  in  1  one-cycle pulse per video frame
crash  in  4  crash[i] = bike i+1 collided this cycle
state  out  3  current FSM state (package encoding)
bikes_enable  out  1  1 only in PLAYING
arena_clear  out  1  one-cycle pulse on every entry to COUNTDOWN
alive  out  4  per-bike alive mask
winner  out  3  0 = none/draw, 1..4 = winning bike; valid from ROUND_OVER onward
round_over  out  1  one-cycle pulse on PLAYING->ROUND_OVER
match_over  out  1  level, high in MATCH_OVER
scores  out  4*SCORE_W  {p4,p3,p2,p1} score counters

Behaviour:
- Reset (resetn=0 at an edge): state=IDLE, alive=0, winner=0, scores=0, all strobes 0, mode latch=0, frame counter=0. Reset wins over every other event in the same cycle, including mid-round.
- States: IDLE, COUNTDOWN, PLAYING, ROUND_OVER, MATCH_OVER.
- IDLE --start--> COUNTDOWN: latch mode, scores=0, winner=0, load counter=COUNTDOWN_FRAMES, pulse arena_clear.
- Entering COUNTDOWN always sets alive=4'b1111 (4P) or 4'b0011 (2P). Unused bikes stay 0 and their crash bits are ignored.
- COUNTDOWN: counter decrements on each frame_tick. On the tick that takes it to 0, go to PLAYING on the next edge. Crash is ignored.
- PLAYING: bikes_enable=1. Each cycle, next_alive = alive & ~crash (masked to active bikes). The alive register takes next_alive.
  - 2P end condition: any active bike crashes, i.e. popcount(next_alive) < 2.
  - 4P end condition: popcount(next_alive) <= 1.
  - On end: go to ROUND_OVER the next edge (1-cycle latency from the crash sample) and pulse round_over.
  - winner = index+1 of the sole remaining alive bike; 0 if none remain (simultaneous final crashes = draw).
  - The winner's score increments in the same edge, saturating at 2^SCORE_W-1. A draw changes no score.
  - Load counter=ROUND_OVER_FRAMES.
- ROUND_OVER: bikes_enable=0, crash ignored. Counter decrements per frame_tick. At 0:
  - if any score >= WIN_SCORE, go to MATCH_OVER;
  - else go to COUNTDOWN (arena_clear pulse, alive restored, counter reloaded, winner kept until the next round_over).
- MATCH_OVER: match_over=1, scores and winner held. start -> COUNTDOWN with scores cleared and mode re-latched, as from IDLE.
- start is ignored in COUNTDOWN, PLAYING and ROUND_OVER.
- frame_tick and end-of-round in the same cycle: the transition is taken; the tick is not carried into the new counter.
- A counter parameter of 0 is illegal. The bench uses parameter values >= 1.

Decomposition:
- Shared package lightbike_pkg:
  - state encodings (IDLE=0, COUNTDOWN=1, PLAYING=2, ROUND_OVER=3, MATCH_OVER=4);
  - WINNER_NONE=0;
  - popcount4 function;
  - default frame constants.
- One sub-module: frame_down_counter. It takes load, load_value, tick and outputs done (count==0 and tick), 8-bit width.

Test Plan:
1. Reset in PLAYING with a crash asserted in the same cycle -> next cycle state=IDLE, scores=0, alive=0, winner=0.
2. 2P, COUNTDOWN_FRAMES=2: start, 2 ticks -> PLAYING. crash=4'b0010 -> next cycle ROUND_OVER, winner=1, p1=1, round_over pulses exactly once.
3. 2P: crash=4'b0011 in the same cycle -> winner=0, scores unchanged. crash on bits 3:2 during play -> no effect.
4. 4P: crashes 0001, then 0100, then 1000 in separate cycles -> ends only after the third, winner=2. Alternative: final two crash together (alive 0110, crash 0110) -> winner=0.
5. WIN_SCORE=2: bike 1 wins two rounds -> after ROUND_OVER_FRAMES ticks, MATCH_OVER, match_over=1. start -> COUNTDOWN, scores=0, arena_clear pulses.
6. Crash during COUNTDOWN/ROUND_OVER and start during PLAYING -> ignored. Tick coincident with end-of-round -> counter=ROUND_OVER_FRAMES.
